filter2d_rd_stream: RTL and testbench

Downstream readback stage for the 2-D filter. On a start pulse, normally tied to the filter's `finish`, it reads the filtered frame from the output half of the shared single-port image buffer. It emits the pixels in raster order as a valid/ready stream with start-of-frame and end-of-line markers. While `busy` is high it owns the buffer's memory port; the top-level mux selects its `cs`/`we`/`addr`.

---
 rtl/filter2d_pkg.sv | 10 +
 rtl/filter2d_rd_stream_if.sv | 24 ++
 rtl/pix_fifo.sv | 49 ++++
 rtl/filter2d_rd_stream.sv | 134 +++++++++++++
 tb/tb_filter2d_rd_stream.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/filter2d_pkg.sv
// Shared constants and state encoding for the 2-D filter readback path.
package filter2d_pkg;
  localparam int IMG_W    = 256;
  localparam int IMG_H    = 256;
  localparam int OUT_BASE = 65536;
  localparam int AW       = 17;
  localparam int DW       = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/filter2d_rd_stream_if.sv
// Memory read port plus outgoing pixel stream of the readback stage.
interface filter2d_rd_stream_if #(
  parameter int AW = filter2d_pkg::AW,
  parameter int DW = filter2d_pkg::DW
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;

  modport master (
    output cs, we, addr, m_valid, m_data, m_sof, m_eol,
    input  mem_dout, m_ready
  );
  modport slave (
    input  cs, we, addr, m_valid, m_data, m_sof, m_eol,
    output mem_dout, m_ready
  );
endinterface

// File: rtl/pix_fifo.sv
// Small synchronous pixel FIFO; depth must be a power of two so the
// pointers wrap naturally.
module pix_fifo #(
  parameter int DW     = 8,
  parameter int FIFO_D = 4,
  localparam int PW    = $clog2(FIFO_D),
  localparam int CW    = $clog2(FIFO_D + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [FIFO_D-1:0][DW-1:0] mem;
  logic [PW-1:0]             wp, rp;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_D));
  assign dout  = mem[rp];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));
endmodule

// File: rtl/filter2d_rd_stream.sv
// Frame readback: streams the filtered frame out of the shared buffer in
// raster order with credit-limited reads so the output FIFO never overflows.
module filter2d_rd_stream #(
  parameter int IMG_W    = filter2d_pkg::IMG_W,
  parameter int IMG_H    = filter2d_pkg::IMG_H,
  parameter int OUT_BASE = filter2d_pkg::OUT_BASE,
  parameter int AW       = filter2d_pkg::AW,
  parameter int DW       = filter2d_pkg::DW,
  parameter int FIFO_D   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  filter2d_rd_stream_if.master bus
);
  import filter2d_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int OCW  = $clog2(FIFO_D + 1);

  if ((longint'(OUT_BASE) + longint'(NPIX) - 1) >= (longint'(1) << AW)) begin : g_addr_chk
    $error("filter2d_rd_stream: output frame does not fit in AW address bits");
  end
  if ((FIFO_D < 4) || ((FIFO_D & (FIFO_D - 1)) != 0)) begin : g_fifo_chk
    $error("filter2d_rd_stream: FIFO_D must be a power of two and at least 4");
  end

  rd_state_t      state, state_nxt;
  logic [CW-1:0]  rd_cnt;
  logic [XW-1:0]  out_x;
  logic [YW-1:0]  out_y;
  logic           cs_d;
  logic           issue;
  logic           pop;
  logic           last_hs;
  logic [OCW-1:0] occ;
  logic           f_empty, f_full;
  logic [DW-1:0]  f_dout;

  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);
  assign bus.we  = 1'b0;

  assign pop     = !f_empty && bus.m_ready;
  assign last_hs = pop && (out_x == XW'(IMG_W - 1)) && (out_y == YW'(IMG_H - 1));

  assign bus.m_valid = !f_empty;
  assign bus.m_data  = f_dout;
  assign bus.m_sof   = !f_empty && (out_x == '0) && (out_y == '0);
  assign bus.m_eol   = !f_empty && (out_x == XW'(IMG_W - 1));

  // cs_d is the read whose data lands this cycle; cs is the read the memory
  // samples at this edge. Both already hold a FIFO slot.
  pix_fifo #(.DW(DW), .FIFO_D(FIFO_D)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cs_d),
    .din     (bus.mem_dout),
    .pop     (pop),
    .dout    (f_dout),
    .empty   (f_empty),
    .full    (f_full),
    .count   (occ)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a start outside IDLE is simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rd_cnt == CW'(NPIX)) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credit check: issue only if the slot is free once every in-flight read has landed.
  always_comb begin
    issue = 1'b0;
    if (((state == RUN) || ((state == IDLE) && start)) && (rd_cnt != CW'(NPIX)))
      issue = (int'(occ) + int'(cs_d) + int'(bus.cs) - int'(pop)) < FIFO_D;
  end

  // Read request pipeline and read address counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cs   <= 1'b0;
      bus.addr <= '0;
      cs_d     <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      bus.cs <= issue;
      cs_d   <= bus.cs;
      if (issue) begin
        bus.addr <= AW'(OUT_BASE) + AW'(rd_cnt);
        rd_cnt   <= rd_cnt + CW'(1);
      end else if (state == DONE) begin
        rd_cnt <= '0;
      end
    end
  end

  // Output raster position, advanced on every stream handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_x <= '0;
      out_y <= '0;
    end else if ((state == IDLE) && start) begin
      out_x <= '0;
      out_y <= '0;
    end else if (pop) begin
      if (out_x == XW'(IMG_W - 1)) begin
        out_x <= '0;
        out_y <= (out_y == YW'(IMG_H - 1)) ? '0 : out_y + YW'(1);
      end else begin
        out_x <= out_x + XW'(1);
      end
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (!reset_n) !(cs_d && f_full && !pop));
endmodule

// File: tb/tb_filter2d_rd_stream.sv
// Bench for filter2d_rd_stream on an 8x4 frame: reference is the memory
// image read out in raster order with sof/eol derived from the pixel index.
module tb_filter2d_rd_stream;
  localparam int W      = 8;
  localparam int H      = 4;
  localparam int N      = W * H;
  localparam int IW     = $clog2(N);
  localparam int OB     = 65536;
  localparam int AW     = 17;
  localparam int DW     = 8;
  localparam int FD     = 4;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  int total = 0;
  int bad = 0;
  int k, cs_cnt, done_cnt, done_j, first_v;
  bit prev_stall;
  logic [DW-1:0] pd;
  logic ps, pe;
  logic [DW-1:0] mem [N];

  filter2d_rd_stream_if #(.AW(AW), .DW(DW)) bus ();

  filter2d_rd_stream #(
    .IMG_W(W), .IMG_H(H), .OUT_BASE(OB), .AW(AW), .DW(DW), .FIFO_D(FD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port buffer: data valid the cycle after cs.
  always @(posedge clk) begin : mem_model
    int a;
    logic [IW-1:0] ai;
    if (bus.cs) begin
      a  = int'(bus.addr) - OB;
      ai = a[IW-1:0];
      if (a >= 0 && a < N) bus.mem_dout <= mem[ai];
      else                 bus.mem_dout <= 'x;
    end
  end

  function automatic logic [DW-1:0] pix(input int idx);
    logic [IW-1:0] i;
    i = idx[IW-1:0];
    return mem[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample point per cycle (negedge): check the stream, then pick m_ready for the next edge.
  task automatic cyc_chk(input int j, input int mode);
    logic rdy;
    if (bus.cs) cs_cnt++;
    if (done) begin
      done_cnt++;
      if (done_j < 0) done_j = j;
      chk("busy_at_done", busy, 0);
    end
    if (bus.m_valid && first_v < 0) first_v = j;
    chk("inflight_le_depth", (cs_cnt - k <= FD), 1);
    if (prev_stall) begin
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_data", bus.m_data, pd);
      chk("hold_sof", bus.m_sof, ps);
      chk("hold_eol", bus.m_eol, pe);
    end
    case (mode)
      1:       rdy = ($urandom_range(0, 1) == 1);
      2:       rdy = (j >= 100);
      default: rdy = 1'b1;
    endcase
    bus.m_ready = rdy;
    if (bus.m_valid) begin
      if (k < N) begin
        chk("data", bus.m_data, pix(k));
        chk("sof", bus.m_sof, (k == 0));
        chk("eol", bus.m_eol, ((k % W) == W - 1));
      end else begin
        chk("extra_pixel_valid", bus.m_valid, 0);
      end
      if (rdy) k++;
    end else begin
      chk("sof_idle", bus.m_sof, 0);
      chk("eol_idle", bus.m_eol, 0);
    end
    prev_stall = bus.m_valid && !rdy;
    pd = bus.m_data;
    ps = bus.m_sof;
    pe = bus.m_eol;
  endtask

  // mode 0: sink always ready, 1: random ready, 2: ready held low for 100 cycles.
  // restart_j >= 0 pulses start again mid-frame; abort_k >= 0 resets after that many pixels.
  task automatic frame(input int mode, input int restart_j, input int abort_k);
    int j;
    bit fin;
    k = 0; cs_cnt = 0; done_cnt = 0; done_j = -1; first_v = -1; prev_stall = 0;
    foreach (mem[i]) mem[i] = DW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    fin = 0;
    while (!fin) begin
      if (abort_k >= 0 && k == abort_k) begin
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", bus.cs, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_sof", bus.m_sof, 0);
        chk("rst_eol", bus.m_eol, 0);
        chk("rst_data", bus.m_data, 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_done", done, 0);
        end
        reset_n = 1'b1;
        fin = 1;
      end else begin
        cyc_chk(j, mode);
        if (j == 0) begin
          chk("e0_busy", busy, 1);
          chk("e0_cs", bus.cs, 1);
          chk("e0_addr", bus.addr, OB);
        end
        if (mode == 2 && j == 99) begin
          chk("stall_cs_pulses", cs_cnt, 4);
          chk("stall_cs_low", bus.cs, 0);
        end
        if (done_j >= 0 && j >= done_j + 3) begin
          fin = 1;
        end else if (j >= BUDGET) begin
          chk("timeout_done_seen", (done_j >= 0), 1);
          fin = 1;
        end else begin
          start = (j == restart_j);
          @(negedge clk);
          j++;
        end
      end
    end
    start = 1'b0;
    if (abort_k >= 0) begin
      chk("abort_no_done", done_cnt, 0);
    end else begin
      chk("pix_count", k, N);
      chk("done_once", done_cnt, 1);
      chk("idle_busy", busy, 0);
      if (mode == 0) begin
        chk("first_valid_cycle", first_v, 2);
        chk("done_cycle", done_j, N + 2);
      end
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cs", bus.cs, 0);
    chk("reset_we", bus.we, 0);
    chk("reset_addr", bus.addr, 0);
    chk("reset_valid", bus.m_valid, 0);
    chk("reset_sof", bus.m_sof, 0);
    chk("reset_eol", bus.m_eol, 0);
    chk("reset_data", bus.m_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    frame(0, -1, -1);   // full rate, exact timing
    frame(1, -1, -1);   // random backpressure
    frame(1, -1, -1);
    frame(2, -1, -1);   // long initial stall: credit limit
    frame(0, 10, -1);   // second start mid-frame is ignored
    frame(0, -1, 20);   // reset mid-frame
    frame(0, -1, -1);   // clean frame after abort restarts at OUT_BASE

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
